// File: rtl/hbus_types_pkg.sv
// Shared constants and burst FSM state type for the hbus register-bank receiver.
package hbus_types_pkg;

    localparam logic [7:0] CTRL_RST = 8'h5A;
    localparam logic [7:0] RO_VAL   = 8'hAA;

    localparam int ID_TABLE_N = 8;
    localparam logic [7:0] ID_TABLE [ID_TABLE_N] = '{
        8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88
    };

    typedef enum logic [1:0] {IDLE, WR, RD} hbus_burst_state_e;

    // Deeper tables repeat the base pattern.
    function automatic logic [7:0] id_rom(input int unsigned idx);
        return ID_TABLE[idx % ID_TABLE_N];
    endfunction

endpackage

// File: rtl/hbus_id_table.sv
// ID table: read pointer into a constant ROM; load sets the pointer, advance steps it with wrap.
module hbus_id_table
    import hbus_types_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ID_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int PTR_W = (ID_DEPTH > 1) ? $clog2(ID_DEPTH) : 1;

    logic [PTR_W-1:0] ptr_q;

    // Out-of-range load values park the pointer at entry 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (load) begin
            if (32'(wdata) < ID_DEPTH) ptr_q <= PTR_W'(wdata);
            else                       ptr_q <= '0;
        end else if (advance) begin
            if (ptr_q == PTR_W'(ID_DEPTH - 1)) ptr_q <= '0;
            else                               ptr_q <= ptr_q + PTR_W'(1);
        end
    end

    assign rdata = DATA_W'(id_rom(32'(ptr_q)));

endmodule

// File: rtl/hbus_rx_burst.sv
// hbus burst register-bank receiver: CTRL/STATUS/ID/RO/AND map with auto-incrementing bursts.
// Optional unmapped-address flag enabled by defining HBUS_RX_BURST_ERR_EN.
module hbus_rx_burst
    import hbus_types_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int NUM_CTRL  = 4,
    parameter int ID_DEPTH  = 8,
    parameter int MAX_BURST = 16,
    localparam int LEN_W    = $clog2(MAX_BURST)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       hen,
    input  logic                       hwr_rd,
    input  logic [ADDR_W-1:0]          haddr,
    input  logic [LEN_W-1:0]           hlen,
    input  logic [DATA_W-1:0]          hwdata,
    output logic [DATA_W-1:0]          hrdata,
    output logic                       hrvalid,
    output logic                       hdone,
    output logic                       herr,
    output logic [NUM_CTRL*DATA_W-1:0] ctrl_q
);

    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(NUM_CTRL);
    localparam logic [ADDR_W-1:0] A_ID     = ADDR_W'(NUM_CTRL + 1);
    localparam logic [ADDR_W-1:0] A_RO     = ADDR_W'(NUM_CTRL + 2);
    localparam logic [ADDR_W-1:0] A_AND    = ADDR_W'(NUM_CTRL + 3);

    hbus_burst_state_e state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [LEN_W-1:0]  len_q;

    logic [DATA_W-1:0]   ctrl_r [NUM_CTRL];
    logic [NUM_CTRL-1:0] status_q;
    logic [DATA_W-1:0]   and_q;
    logic [DATA_W-1:0]   id_rdata;
    logic [DATA_W-1:0]   rd_val;

    // Handshake: hen high means one beat is accepted in that cycle, no back-pressure.
    // The first beat (from IDLE) takes direction/address/length from the bus; later
    // beats use the captured values. hen low mid-burst aborts the burst.
    logic              beat_wr;
    logic [ADDR_W-1:0] beat_addr;
    logic              beat_last;
    logic              is_ctrl, is_status, is_id, is_ro, is_and;

    always_comb begin
        beat_wr   = (state_q == IDLE) ? hwr_rd : (state_q == WR);
        beat_addr = (state_q == IDLE) ? haddr  : addr_q;
        beat_last = (state_q == IDLE) ? (hlen == '0) : (cnt_q == len_q);
        is_ctrl   = (beat_addr < ADDR_W'(NUM_CTRL));
        is_status = (beat_addr == A_STATUS);
        is_id     = (beat_addr == A_ID);
        is_ro     = (beat_addr == A_RO);
        is_and    = (beat_addr == A_AND);
    end

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_CTRL; i++) begin
            if (beat_addr == ADDR_W'(i)) rd_val = ctrl_r[i];
        end
        if (is_status) rd_val = DATA_W'(status_q);
        if (is_id)     rd_val = id_rdata;
        if (is_ro)     rd_val = DATA_W'(RO_VAL);
        if (is_and)    rd_val = and_q;
    end

    hbus_id_table #(
        .DATA_W   (DATA_W),
        .ID_DEPTH (ID_DEPTH)
    ) u_id_table (
        .clk     (clk),
        .rst     (rst),
        .load    (hen && beat_wr && is_id),
        .advance (hen && !beat_wr && is_id),
        .wdata   (hwdata),
        .rdata   (id_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            len_q    <= '0;
            status_q <= '1;
            and_q    <= '1;
            hrdata   <= '0;
            hrvalid  <= 1'b0;
            hdone    <= 1'b0;
            for (int i = 0; i < NUM_CTRL; i++) ctrl_r[i] <= DATA_W'(CTRL_RST);
        end else begin
            hrvalid <= 1'b0;
            hdone   <= 1'b0;
            if (hen) begin
                if (beat_wr) begin
                    for (int i = 0; i < NUM_CTRL; i++) begin
                        if (beat_addr == ADDR_W'(i)) begin
                            ctrl_r[i]   <= hwdata;
                            status_q[i] <= hwdata[0];
                        end
                    end
                    if (is_and) and_q <= and_q & hwdata;
                end else begin
                    hrdata  <= rd_val;
                    hrvalid <= 1'b1;
                    if (is_and) and_q <= '1;
                end
                if (state_q == IDLE) len_q <= hlen;
                if (beat_last) begin
                    state_q <= IDLE;
                    hdone   <= 1'b1;
                end else begin
                    state_q <= beat_wr ? WR : RD;
                    addr_q  <= beat_addr + ADDR_W'(1);
                    cnt_q   <= (state_q == IDLE) ? LEN_W'(1) : cnt_q + LEN_W'(1);
                end
            end else begin
                state_q <= IDLE;
            end
        end
    end

`ifdef HBUS_RX_BURST_ERR_EN
    // Flag lines up with hrvalid for reads and follows the beat for writes.
    always_ff @(posedge clk) begin
        if (rst) herr <= 1'b0;
        else     herr <= hen && !(is_ctrl || is_status || is_id || is_ro || is_and);
    end
`else
    assign herr = 1'b0;
`endif

    for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl_out
        assign ctrl_q[g*DATA_W +: DATA_W] = ctrl_r[g];
    end

endmodule
